// File: rtl/calc_pkg.sv
// Shared constants for the accumulating calculator: operation codes, FSM
// state encodings and default operand/result widths.
package calc_pkg;

   localparam int unsigned W_DEF  = 8;
   localparam int unsigned RW_DEF = 32;

   localparam logic [2:0] FN_ADD = 3'b000;
   localparam logic [2:0] FN_SUB = 3'b001;
   localparam logic [2:0] FN_MUL = 3'b010;
   localparam logic [2:0] FN_DIV = 3'b011;
   localparam logic [2:0] FN_MOD = 3'b100;
   localparam logic [2:0] FN_SQR = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. valid_o pulses for one
// cycle RW cycles after start_i; abort_i drops any division in progress.
module seq_divider #(
   parameter int unsigned RW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [RW-1:0] dividend_i,
   input  logic [RW-1:0] divisor_i,
   output logic          busy_o,
   output logic          valid_o,
   output logic [RW-1:0] quotient_o,
   output logic [RW-1:0] remainder_o
);

   localparam int unsigned CW = $clog2(RW + 1);

   logic [RW-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d, valid_q, valid_d;
   logic [RW:0]   shifted, diff;

   always_comb begin
      shifted = {rem_q, quo_q[RW-1]};
      diff    = shifted - {1'b0, dvs_q};
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      if (abort_i) begin
         rem_d  = '0;
         quo_d  = '0;
         dvs_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (start_i) begin
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
         cnt_d  = CW'(RW);
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Partial remainder stays below the divisor, so RW+1 bits suffice.
         rem_d = diff[RW] ? shifted[RW-1:0] : diff[RW-1:0];
         quo_d = {quo_q[RW-2:0], ~diff[RW]};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o      = busy_q;
   assign valid_o     = valid_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/calculator_acc.sv
// Accumulating calculator: single-cycle add/sub/mul/square, multi-cycle
// div/mod via seq_divider, with error flag and first-operand mode.
module calculator_acc
   import calc_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    func,
   input  logic          button,
   input  logic          clear,
   input  logic [W-1:0]  num1,
   input  logic [W-1:0]  num2,
   output logic [RW-1:0] cal_result,
   output logic          busy,
   output logic          done,
   output logic          err
);

   logic [1:0]    state_q, state_d;
   logic [RW-1:0] res_q, res_d;
   logic          btn_q, done_q, done_d, err_q, err_d;
   logic          first_q, first_d, mod_q, mod_d;
   logic [RW-1:0] a_op, b_op, alu;
   logic          btn_edge, div_start, div_busy, div_valid;
   logic [RW-1:0] div_quo, div_rem;

   assign a_op     = first_q ? RW'(num1) : res_q;
   assign b_op     = RW'(num2);
   assign btn_edge = button & ~btn_q;

   always_comb begin
      case (func)
         FN_ADD:  alu = a_op + b_op;
         FN_SUB:  alu = a_op - b_op;
         FN_MUL:  alu = a_op * b_op;
         FN_SQR:  alu = a_op * a_op;
         default: alu = a_op;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      err_d     = err_q;
      first_d   = first_q;
      mod_d     = mod_q;
      done_d    = 1'b0;
      div_start = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         res_d   = '0;
         err_d   = 1'b0;
         first_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (btn_edge) begin
               case (func)
                  FN_ADD, FN_SUB, FN_MUL, FN_SQR: begin
                     res_d   = alu;
                     err_d   = 1'b0;
                     done_d  = 1'b1;
                     first_d = 1'b0;
                  end
                  FN_DIV, FN_MOD: begin
                     if (b_op == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                     end else if (!div_busy) begin
                        div_start = 1'b1;
                        mod_d     = (func == FN_MOD);
                        state_d   = ST_DIV;
                     end
                  end
                  default: begin
                     err_d  = 1'b1;
                     done_d = 1'b1;
                  end
               endcase
            end
            ST_DIV: if (div_valid) begin
               res_d   = mod_q ? div_rem : div_quo;
               err_d   = 1'b0;
               done_d  = 1'b1;
               first_d = 1'b0;
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         btn_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         first_q <= 1'b1;
         mod_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         btn_q   <= button;
         done_q  <= done_d;
         err_q   <= err_d;
         first_q <= first_d;
         mod_q   <= mod_d;
      end
   end

   seq_divider #(.RW(RW)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (div_start),
      .abort_i     (clear),
      .dividend_i  (a_op),
      .divisor_i   (b_op),
      .busy_o      (div_busy),
      .valid_o     (div_valid),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   assign cal_result = res_q;
   assign busy       = (state_q == ST_DIV);
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_calculator_acc.sv
// Self-checking bench for calculator_acc: directed scenarios plus random
// operation sequences compared against an arithmetic reference model.
module tb_calculator_acc;

   localparam int unsigned W  = 8;
   localparam int unsigned RW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    func = 3'b000;
   logic          button = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  num1 = '0;
   logic [W-1:0]  num2 = '0;
   logic [RW-1:0] cal_result;
   logic          busy, done, err;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [RW-1:0] m_acc   = '0;
   logic          m_first = 1'b1;

   calculator_acc #(.W(W), .RW(RW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .func       (func),
      .button     (button),
      .clear      (clear),
      .num1       (num1),
      .num2       (num2),
      .cal_result (cal_result),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Model: result, error and the edge (relative to the press edge T) at
   // which cal_result is written.
   task automatic model_op(input logic [2:0] f, input logic [W-1:0] n1,
                           input logic [W-1:0] n2, output logic [RW-1:0] r,
                           output logic e, output int lat);
      logic [RW-1:0] a, b;
      a   = m_first ? RW'(n1) : m_acc;
      b   = RW'(n2);
      e   = 1'b0;
      lat = 0;
      r   = m_acc;
      case (f)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a * b;
         3'd3: if (b == 0) e = 1'b1; else begin r = a / b; lat = RW + 1; end
         3'd4: if (b == 0) e = 1'b1; else begin r = a % b; lat = RW + 1; end
         3'd5: r = a * a;
         default: e = 1'b1;
      endcase
      if (!e) begin
         m_acc   = r;
         m_first = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_acc   = '0;
      m_first = 1'b1;
   endtask

   // Press the button once; report the edge index (0 = edge T) at which the
   // result appeared, or -1 if no done pulse within the budget.
   task automatic run_op(input logic [2:0] f, input logic [W-1:0] n1,
                         input logic [W-1:0] n2, output logic [RW-1:0] r,
                         output logic e, output int lat);
      @(negedge clk);
      func = f; num1 = n1; num2 = n2; button = 1'b1;
      @(posedge clk);
      lat = -1; r = '0; e = 1'b0;
      for (int k = 1; k <= int'(RW) + 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            button = 1'b0;
            num1 = W'($urandom);
            num2 = W'($urandom);
            func = 3'($urandom);
         end
         if (done) begin
            lat = k - 1; r = cal_result; e = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cal_result, busy, done, err} !== {{RW{1'b0}}, 3'b000})
         $display("FAIL reset_outputs got res=%h busy=%b done=%b err=%b exp all 0",
                  cal_result, busy, done, err);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [RW-1:0] r; logic e; int lat;
      run_op(3'b000, 8'h12, 8'h34, r, e, lat);
      n_checks++;
      if (r !== 32'h46 || e !== 1'b0 || lat != 0)
         $display("FAIL add_vec got res=%h err=%b lat=%0d exp res=46 err=0 lat=0", r, e, lat);
      else n_pass++;
      run_op(3'b010, 8'h99, 8'h10, r, e, lat);
      n_checks++;
      if (r !== 32'h460 || e !== 1'b0 || lat != 0)
         $display("FAIL mul_acc got res=%h err=%b lat=%0d exp res=460 err=0 lat=0", r, e, lat);
      else n_pass++;
      do_clear();
      run_op(3'b011, 8'hC8, 8'h07, r, e, lat);
      n_checks++;
      if (r !== 32'h1C || e !== 1'b0 || lat != int'(RW) + 1)
         $display("FAIL div_vec got res=%h err=%b lat=%0d exp res=1c err=0 lat=%0d", r, e, lat, RW + 1);
      else n_pass++;
      do_clear();
      run_op(3'b100, 8'hC8, 8'h07, r, e, lat);
      n_checks++;
      if (r !== 32'h4 || e !== 1'b0 || lat != int'(RW) + 1)
         $display("FAIL mod_vec got res=%h err=%b lat=%0d exp res=4 err=0 lat=%0d", r, e, lat, RW + 1);
      else n_pass++;
      do_clear();
      run_op(3'b011, 8'h05, 8'h00, r, e, lat);
      n_checks++;
      if (r !== 32'h0 || e !== 1'b1 || lat != 0)
         $display("FAIL div_zero got res=%h err=%b lat=%0d exp res=0 err=1 lat=0", r, e, lat);
      else n_pass++;
      run_op(3'b000, 8'h05, 8'h01, r, e, lat);
      n_checks++;
      if (r !== 32'h6 || e !== 1'b0 || lat != 0)
         $display("FAIL add_after_err got res=%h err=%b lat=%0d exp res=6 err=0 lat=0", r, e, lat);
      else n_pass++;
      run_op(3'b111, 8'h01, 8'h01, r, e, lat);
      n_checks++;
      if (r !== 32'h6 || e !== 1'b1 || lat != 0)
         $display("FAIL illegal_func got res=%h err=%b lat=%0d exp res=6 err=1 lat=0", r, e, lat);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [RW-1:0] r, exp_r; logic e, exp_e; int lat, exp_lat;
      logic [2:0] f; logic [W-1:0] n1, n2;
      do_clear();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            do_clear();
            n_checks++;
            if (cal_result !== '0 || err !== 1'b0)
               $display("FAIL rand_clear got res=%h err=%b exp res=0 err=0", cal_result, err);
            else n_pass++;
         end
         f  = 3'($urandom_range(0, 7));
         n1 = W'($urandom);
         n2 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
         model_op(f, n1, n2, exp_r, exp_e, exp_lat);
         run_op(f, n1, n2, r, e, lat);
         n_checks++;
         if (r !== exp_r || e !== exp_e || lat != exp_lat)
            $display("FAIL rand_op%0d f=%0d n1=%h n2=%h got res=%h err=%b lat=%0d exp res=%h err=%b lat=%0d",
                     i, f, n1, n2, r, e, lat, exp_r, exp_e, exp_lat);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0)
            $display("FAIL rand_done_width%0d got done=%b exp 0", i, done);
         else n_pass++;
      end
   endtask

   task automatic test_busy_ignore();
      int seen; logic [RW-1:0] r;
      do_clear();
      @(negedge clk);
      func = 3'b011; num1 = 8'hC8; num2 = 8'h07; button = 1'b1;
      @(posedge clk);
      seen = -1; r = '0;
      for (int k = 1; k <= int'(RW) + 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            func = 3'b000; num1 = 8'hFF; num2 = 8'h01;
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_start got %b exp 1", busy);
            else n_pass++;
         end
         button = (k < int'(RW) - 2) && ((k % 4) >= 2);
         if (done) begin seen = k - 1; r = cal_result; break; end
      end
      n_checks++;
      if (seen != int'(RW) + 1 || r !== 32'h1C || busy !== 1'b0)
         $display("FAIL div_with_presses got res=%h lat=%0d busy=%b exp res=1c lat=%0d busy=0",
                  r, seen, busy, RW + 1);
      else n_pass++;
      // press during the DONE cycle must also be dropped
      button = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen++;
      end
      button = 1'b0;
      n_checks++;
      if (seen != 0 || cal_result !== 32'h1C)
         $display("FAIL done_press_ignored got res=%h pulses=%0d exp res=1c pulses=0", cal_result, seen);
      else n_pass++;
   endtask

   task automatic test_abort();
      int seen; logic [RW-1:0] r; logic e; int lat;
      do_clear();
      @(negedge clk);
      func = 3'b011; num1 = 8'hC8; num2 = 8'h07; button = 1'b1;
      @(posedge clk);
      @(negedge clk);
      button = 1'b0;
      repeat (9) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if (cal_result !== '0 || busy !== 1'b0)
         $display("FAIL clear_abort got res=%h busy=%b exp res=0 busy=0", cal_result, busy);
      else n_pass++;
      seen = 0;
      repeat (int'(RW) + 6) begin @(negedge clk); if (done) seen++; end
      n_checks++;
      if (seen != 0) $display("FAIL clear_abort_done got pulses=%0d exp 0", seen);
      else n_pass++;
      m_acc = '0; m_first = 1'b1;
      run_op(3'b000, 8'h03, 8'h04, r, e, lat);
      n_checks++;
      if (r !== 32'h7 || e !== 1'b0 || lat != 0)
         $display("FAIL first_mode_after_clear got res=%h err=%b lat=%0d exp res=7 err=0 lat=0", r, e, lat);
      else n_pass++;
      @(negedge clk);
      func = 3'b011; num1 = 8'h00; num2 = 8'h07; button = 1'b1;
      @(posedge clk);
      @(negedge clk);
      button = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (cal_result !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
         $display("FAIL reset_abort got res=%h busy=%b done=%b err=%b exp all 0",
                  cal_result, busy, done, err);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (int'(RW) + 6) begin @(negedge clk); if (done || busy) seen++; end
      n_checks++;
      if (seen != 0) $display("FAIL reset_abort_quiet got active_cycles=%0d exp 0", seen);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
